// File: rtl/seg_display_ctrl_pkg.sv
// Shared player-state codes and 7-segment glyphs (active-low, bit 7 = dp).
// Also provides the digit-to-glyph lookup used by the frame builder.
package seg_display_ctrl_pkg;

  localparam logic [1:0] spause = 2'b00;
  localparam logic [1:0] splay  = 2'b01;
  localparam logic [1:0] sstop  = 2'b10;

  localparam logic [7:0] seg_null = 8'hFF;
  localparam logic [7:0] a0 = 8'hC0;
  localparam logic [7:0] a1 = 8'hF9;
  localparam logic [7:0] a2 = 8'hA4;
  localparam logic [7:0] a3 = 8'hB0;
  localparam logic [7:0] a4 = 8'h99;
  localparam logic [7:0] a5 = 8'h92;
  localparam logic [7:0] a6 = 8'h82;
  localparam logic [7:0] a7 = 8'hF8;
  localparam logic [7:0] a8 = 8'h80;
  localparam logic [7:0] a9 = 8'h90;

  localparam logic [7:0] ch_p = 8'h8C;
  localparam logic [7:0] ch_a = 8'h88;
  localparam logic [7:0] ch_u = 8'hC1;
  localparam logic [7:0] ch_s = 8'h92;
  localparam logic [7:0] ch_e = 8'h86;
  localparam logic [7:0] ch_o = 8'hA3;
  localparam logic [7:0] ch_n = 8'hAB;
  localparam logic [7:0] ch_g = 8'hC2;
  localparam logic [7:0] ch_l = 8'hC7;
  localparam logic [7:0] ch_m = 8'hC8;
  localparam logic [7:0] ch_h = 8'h89;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = a0;
      4'd1:    digit_glyph = a1;
      4'd2:    digit_glyph = a2;
      4'd3:    digit_glyph = a3;
      4'd4:    digit_glyph = a4;
      4'd5:    digit_glyph = a5;
      4'd6:    digit_glyph = a6;
      4'd7:    digit_glyph = a7;
      4'd8:    digit_glyph = a8;
      4'd9:    digit_glyph = a9;
      default: digit_glyph = seg_null;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Player-side inputs and panel-side outputs of the 7-seg text controller.
// master = player FSM / test driver, slave = the display controller.
interface seg_display_ctrl_if #(
  parameter int NDIG  = 8,
  parameter int SEL_W = 2
);
  logic [1:0]        states;
  logic [SEL_W-1:0]  song_sel;
  logic [4:0]        music;
  logic [NDIG-1:0]   an;
  logic [7:0]        seg;
  logic [8*NDIG-1:0] frame;

  modport master (output states, song_sel, music, input an, seg, frame);
  modport slave  (input states, song_sel, music, output an, seg, frame);
endinterface

// File: rtl/seg_display_ctrl_scan_mux.sv
// Digit scanner: one slot per SCAN_DIV cycles, an/seg registered one cycle behind frame/idx.
// Anodes stay dark until the first slot boundary after reset, then idx 0 lights first.
module seg_scan_mux
  import seg_display_ctrl_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*NDIG-1:0] frame_i,
  output logic [NDIG-1:0]   an_o,
  output logic [7:0]        seg_o
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);

  logic [DW-1:0]   div_q, div_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            run_q, run_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            term;

  always_comb begin
    term  = (div_q == DW'(SCAN_DIV - 1));
    div_d = term ? '0 : div_q + 1'b1;
    run_d = run_q | term;
    idx_d = idx_q;
    // the very first terminal count only arms the scan so idx 0 gets a full slot
    if (term && run_q) idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    an_d  = '1;
    seg_d = seg_null;
    if (run_q) begin
      for (int i = 0; i < NDIG; i++) begin
        if (idx_q == IW'(i)) begin
          an_d[i] = 1'b0;
          seg_d   = frame_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
      an_q  <= '1;
      seg_q <= seg_null;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      run_q <= run_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
endmodule

// File: rtl/seg_display_ctrl.sv
// Builds the panel text frame from player state (pause blink, note + count, scrolling title).
// Frame is registered one cycle after inputs; an/seg follow one cycle later via seg_scan_mux.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int SEL_W      = 2,
  parameter int NUM_SONGS  = 3,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 50000000,
  parameter int SCROLL_EN  = 1,
  parameter int SCROLL_DIV = 25000000
) (
  input logic             clk,
  input logic             rst,
  seg_display_ctrl_if.slave bus
);
  localparam int OFF_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BW    = $clog2(BLINK_DIV);
  localparam int SW    = $clog2(SCROLL_DIV);

  logic [1:0]        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [4:0]        music_q;
  logic [3:0]        cnt_lo_q, cnt_lo_d, cnt_hi_q, cnt_hi_d;
  logic [BW-1:0]     blink_div_q, blink_div_d;
  logic              blink_on_q, blink_on_d;
  logic [SW-1:0]     scr_div_q, scr_div_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [8*NDIG-1:0] frame_q, frame_d;
  logic [7:0]        txt [8];
  logic              enter, note_ok;
  int                j;

  // counters: note count (BCD), pause blink, stop-mode scroll
  always_comb begin
    enter       = (bus.states != state_q);
    note_ok     = (bus.music >= 5'd1) && (bus.music <= 5'd21);
    cnt_lo_d    = cnt_lo_q;
    cnt_hi_d    = cnt_hi_q;
    blink_div_d = blink_div_q;
    blink_on_d  = blink_on_q;
    scr_div_d   = scr_div_q;
    off_d       = off_q;
    if (bus.states == sstop && enter) begin
      cnt_lo_d = 4'd0;
      cnt_hi_d = 4'd0;
    end else if (bus.states == splay && bus.music != music_q && note_ok) begin
      if (cnt_lo_q == 4'd9) begin
        cnt_lo_d = 4'd0;
        cnt_hi_d = (cnt_hi_q == 4'd9) ? 4'd0 : cnt_hi_q + 4'd1;
      end else begin
        cnt_lo_d = cnt_lo_q + 4'd1;
      end
    end
    if (bus.states == spause) begin
      if (enter) begin
        blink_div_d = '0;
        blink_on_d  = 1'b1;
      end else if (blink_div_q == BW'(BLINK_DIV - 1)) begin
        blink_div_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_div_d = blink_div_q + 1'b1;
      end
    end
    if (bus.states == sstop) begin
      if (enter || bus.song_sel != sel_q) begin
        scr_div_d = '0;
        off_d     = '0;
      end else if (scr_div_q == SW'(SCROLL_DIV - 1)) begin
        scr_div_d = '0;
        off_d     = (off_q == OFF_W'(NDIG - 1)) ? '0 : off_q + 1'b1;
      end else begin
        scr_div_d = scr_div_q + 1'b1;
      end
    end
  end

  // frame text, built on the post-update counter values so the frame never lags them
  always_comb begin
    for (int i = 0; i < 8; i++) txt[i] = seg_null;
    case (bus.states)
      spause: begin
        if (blink_on_d) begin
          txt[5] = ch_p; txt[4] = ch_a; txt[3] = ch_u; txt[2] = ch_s; txt[1] = ch_e;
        end
      end
      splay: begin
        txt[3] = digit_glyph(cnt_hi_d);
        txt[2] = digit_glyph(cnt_lo_d);
        if (bus.music == 5'd0)       txt[0] = a0;
        else if (note_ok)            txt[0] = digit_glyph(4'((bus.music - 5'd1) % 5'd7) + 4'd1);
        if (note_ok && bus.music <= 5'd7)       txt[1] = ch_l;
        else if (note_ok && bus.music <= 5'd14) txt[1] = ch_m;
        else if (note_ok)                       txt[1] = ch_h;
      end
      sstop: begin
        if (int'(bus.song_sel) < NUM_SONGS) begin
          txt[5] = ch_s; txt[4] = ch_o; txt[3] = ch_n; txt[2] = ch_g;
          txt[1] = digit_glyph(4'(bus.song_sel) + 4'd1);
        end
      end
      default: ;
    endcase
    j       = 0;
    frame_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      j = i;
      if (SCROLL_EN != 0 && bus.states == sstop) begin
        j = i - int'(off_d);
        if (j < 0) j = j + NDIG;
      end
      frame_d[8*i +: 8] = txt[3'(j)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= 2'b11;
      sel_q       <= '0;
      music_q     <= '0;
      cnt_lo_q    <= '0;
      cnt_hi_q    <= '0;
      blink_div_q <= '0;
      blink_on_q  <= 1'b1;
      scr_div_q   <= '0;
      off_q       <= '0;
      frame_q     <= {NDIG{seg_null}};
    end else begin
      state_q     <= bus.states;
      sel_q       <= bus.song_sel;
      music_q     <= bus.music;
      cnt_lo_q    <= cnt_lo_d;
      cnt_hi_q    <= cnt_hi_d;
      blink_div_q <= blink_div_d;
      blink_on_q  <= blink_on_d;
      scr_div_q   <= scr_div_d;
      off_q       <= off_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.frame = frame_q;

  seg_scan_mux #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .frame_i (frame_q),
    .an_o    (bus.an),
    .seg_o   (bus.seg)
  );
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: reset, note display/count, blink, scroll, scan.
module tb_seg_display_ctrl;
  import seg_display_ctrl_pkg::*;

  localparam logic [7:0] N = seg_null;
  localparam logic [63:0] BLANK = {8{N}};
  localparam logic [63:0] PAUSE_F = {N, N, ch_p, ch_a, ch_u, ch_s, ch_e, N};

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seg_display_ctrl_if #(.NDIG(8), .SEL_W(2)) bus ();

  seg_display_ctrl #(
    .NDIG(8), .SEL_W(2), .NUM_SONGS(3), .SCAN_DIV(4),
    .BLINK_DIV(16), .SCROLL_EN(1), .SCROLL_DIV(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    logic [63:0] expf;
    logic [7:0]  seen;
    int          idx;
    int          prev_idx;

    rst = 1'b1;
    bus.states = 2'b11; bus.song_sel = 2'd0; bus.music = 5'd0;
    step(2);
    chk("por_an", 64'(bus.an), 64'hFF);
    chk("por_seg", 64'(bus.seg), 64'(N));
    chk("por_frame", bus.frame, BLANK);

    // run a while, then hit reset mid-scan for 3 cycles
    rst = 1'b0; bus.states = splay;
    step(10);
    rst = 1'b1;
    step(1);
    chk("rst_an", 64'(bus.an), 64'hFF);
    chk("rst_seg", 64'(bus.seg), 64'(N));
    chk("rst_frame", bus.frame, BLANK);
    step(2);
    rst = 1'b0;
    step(4);
    chk("an_dark_before_slot", 64'(bus.an), 64'hFF);
    step(1);
    chk("first_an", 64'(bus.an), 64'hFE);
    chk("first_seg", 64'(bus.seg), 64'(a0));
    chk("play_rest", bus.frame, {N, N, N, N, a0, a0, N, a0});

    bus.music = 5'd9;  step(1);
    chk("play_9", bus.frame, {N, N, N, N, a0, a1, ch_m, a2});
    step(1);
    chk("play_9_hold", bus.frame, {N, N, N, N, a0, a1, ch_m, a2});
    bus.music = 5'd15; step(1);
    chk("play_15", bus.frame, {N, N, N, N, a0, a2, ch_h, a1});
    bus.music = 5'd21; step(1);
    chk("play_21", bus.frame, {N, N, N, N, a0, a3, ch_h, a7});

    for (int k = 0; k < 96; k++) begin
      bus.music = (k % 2 == 1) ? 5'd2 : 5'd1;
      step(1);
    end
    chk("count_99", bus.frame, {N, N, N, N, a9, a9, ch_l, a2});
    bus.music = 5'd1;  step(1);
    chk("count_wrap", bus.frame, {N, N, N, N, a0, a0, ch_l, a1});
    bus.music = 5'd22; step(1);
    chk("invalid_note", bus.frame, {N, N, N, N, a0, a0, N, N});
    bus.music = 5'd1;  step(1);
    chk("after_invalid", bus.frame, {N, N, N, N, a0, a1, ch_l, a1});

    bus.states = spause;
    step(1);
    chk("pause_c1", bus.frame, PAUSE_F);
    step(15);
    chk("pause_c16", bus.frame, PAUSE_F);
    step(1);
    chk("pause_c17", bus.frame, BLANK);
    step(15);
    chk("pause_c32", bus.frame, BLANK);
    step(1);
    chk("pause_c33", bus.frame, PAUSE_F);
    step(16);
    chk("pause_c49", bus.frame, BLANK);
    bus.states = splay; step(1);
    chk("count_held_pause", bus.frame, {N, N, N, N, a0, a1, ch_l, a1});
    bus.states = spause; step(1);
    chk("pause_reenter", bus.frame, PAUSE_F);

    bus.states = sstop; bus.song_sel = 2'd1;
    step(1);
    chk("stop_base", bus.frame, {N, N, ch_s, ch_o, ch_n, ch_g, a2, N});
    step(7);
    chk("stop_c8", bus.frame, {N, N, ch_s, ch_o, ch_n, ch_g, a2, N});
    step(1);
    chk("stop_rot1", bus.frame, {N, ch_s, ch_o, ch_n, ch_g, a2, N, N});
    step(7);
    bus.song_sel = 2'd2;
    step(1);
    chk("stop_sel_change", bus.frame, {N, N, ch_s, ch_o, ch_n, ch_g, a3, N});

    bus.states = splay; step(1);
    chk("count_cleared_stop", bus.frame, {N, N, N, N, a0, a0, ch_l, a1});
    bus.music = 5'd5; step(1);
    chk("play_5", bus.frame, {N, N, N, N, a0, a1, ch_l, a5});
    bus.states = 2'b11; step(1);
    chk("state_11_blank", bus.frame, BLANK);
    bus.states = splay; step(1);
    chk("count_held_11", bus.frame, {N, N, N, N, a0, a1, ch_l, a5});
    bus.states = sstop; bus.song_sel = 2'd3; step(1);
    chk("stop_bad_song", bus.frame, BLANK);

    bus.states = splay; bus.music = 5'd12;
    step(3);
    expf = {N, N, N, N, a0, a1, ch_m, a5};
    chk("play_12", bus.frame, expf);
    seen = '0;
    prev_idx = -1;
    for (int c = 0; c < 36; c++) begin
      step(1);
      idx = -1;
      for (int k = 0; k < 8; k++) if (!bus.an[k]) idx = k;
      chk("an_onecold", 64'($onehot(~bus.an)), 64'd1);
      if (idx >= 0) begin
        chk("seg_of_idx", 64'(bus.seg), 64'(expf[8*idx +: 8]));
        seen[idx] = 1'b1;
        if (prev_idx >= 0 && idx != prev_idx) chk("idx_order", 64'(idx), 64'((prev_idx + 1) % 8));
        prev_idx = idx;
      end
    end
    chk("all_digits_scanned", 64'(seen), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
